imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RV decode stage. It takes an instruction word plus a tag through a valid/ready handshake and produces the sign- or zero-extended immediate one cycle later. It covers I/S/B/J/U/shamt/CSR-zimm formats and can take the format from an external select or derive it from the opcode. A 2-entry skid buffer keeps full throughput with a registered in_ready; flush support lets the pipeline drop in-flight entries on redirect.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 5, width of the sideband tag (e.g. rd or ROB index) carried with each entry.
AUTO_SEL, 0, 1 = format derived from opcode and imm_sel ignored; 0 = imm_sel used.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
flush  in  1  drops all buffered entries.
in_valid  in  1  input entry valid.
in_ready  out  1  block can accept an entry; registered.
instr  in  32  instruction word.
imm_sel  in  3  format select, used when AUTO_SEL=0.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output entry valid.
out_ready  in  1  consumer accepts the output entry.
out_imm  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Format encodings, with sign bit instr[31] extended to XLEN:
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - 101 shamt: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 110 zimm: zero-extended instr[19:15].
  - 111: zero.
- AUTO_SEL=1 opcode map:
  - OP-IMM (0010011): shamt if funct3 is 001 or 101, else I.
  - Load (0000011) and JALR (1100111): I.
  - Store (0100011): S.
  - Branch (1100011): B.
  - JAL (1101111): J.
  - LUI/AUIPC (0110111/0010111): U.
  - SYSTEM (1110011): zimm if funct3[2]=1, else I.
  - Any other opcode: zero.
- Immediate is computed combinationally from instr at accept time and stored; latency is exactly 1 cycle from accept to out_valid.
- Storage is a main register (drives the outputs) plus one skid register. States, by valid bits:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: main and skid both valid.
- Handshake signals:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready is registered and equals !skid_valid.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & pop -> ONE, main loaded with the new entry.
    - accept & !pop -> FULL, new entry goes to skid.
    - pop & !accept -> EMPTY.
  - FULL (in_ready=0):
    - pop -> ONE, skid moves to main.
    - otherwise hold.
- Ordering is strict FIFO; no entry is dropped or duplicated except by flush or reset.
- While out_valid=1 and out_ready=0, out_imm and out_tag are stable.
- flush takes priority over a simultaneous accept or pop: next state EMPTY, in_ready=1; the entry offered in the flush cycle is discarded.
- Reset (including mid-transfer): out_valid=0, out_imm=0, out_tag=0, in_ready=1, skid cleared. Reset overrides flush.
- Register data fields load only on accept/move, to avoid needless toggling.

Optional Feature:
IMM_ILLEGAL_CHECK_EN
- Defined: adds output port out_illegal (1 bit), registered alongside out_imm and valid only when out_valid=1. It is 1 when AUTO_SEL=1 and the opcode is not in the map, or when AUTO_SEL=0 and imm_sel=111. It resets to 0 and is carried through the skid buffer.
- Undefined: the port and its logic are absent; the unmapped format yields zero silently.

Test Plan:
1. AUTO_SEL=1, instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF.
2. Store 0xFE512E23 -> out_imm=0xFFFFFFFC. Branch 0xFE000CE3 -> out_imm=0xFFFFFFF8. JAL 0xFFDFF0EF -> out_imm=0xFFFFFFFC. LUI 0x123450B7 -> out_imm=0x12345000. With XLEN=64, the store gives 0xFFFFFFFFFFFFFFFC.
3. Back-pressure: send tags 1,2,3 back-to-back with out_ready=0 -> in_ready falls after tag 2 accepted, tag 3 is held off. Release out_ready -> outputs appear in order 1,2,3 on consecutive cycles with no bubble once released.
4. Flush in the FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, no pending entry is ever emitted.
5. AUTO_SEL=0: imm_sel=101 with instr=0x01F0D093 (srli, shamt 31) -> 0x0000001F. imm_sel=110 with rs1 field=0x1F -> 0x0000001F.
6. Assert rst for 1 cycle while FULL -> all outputs at reset values and in_ready=1. With IMM_ILLEGAL_CHECK_EN, opcode 0x7F -> out_imm=0, out_illegal=1.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: decode-side bus for the immediate generator.
//   Input stream : in_valid/in_ready handshake carrying instr, imm_sel, in_tag.
//   Output stream: out_valid/out_ready handshake carrying out_imm, out_tag
//                  (and out_illegal when IMM_ILLEGAL_CHECK_EN is defined).
//   flush        : drops every buffered entry.
// Modports: master = producer/consumer side (decode logic or bench),
//           slave  = the immediate generator itself.
// XLEN and TAG_W must match the parameters of the connected imm_gen_pipe.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [2:0]       imm_sel;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
`ifdef IMM_ILLEGAL_CHECK_EN
   logic             out_illegal;
`endif

   modport master (
      output flush, in_valid, instr, imm_sel, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag
`ifdef IMM_ILLEGAL_CHECK_EN
      , input out_illegal
`endif
   );

   modport slave (
      input  flush, in_valid, instr, imm_sel, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag
`ifdef IMM_ILLEGAL_CHECK_EN
      , output out_illegal
`endif
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a 2-entry skid
// buffer. The immediate is formed combinationally from instr when an entry
// is accepted and appears on the outputs exactly one cycle later.
//
// Parameters:
//   XLEN     - immediate width, 32 or 64.
//   TAG_W    - width of the sideband tag carried with each entry.
//   AUTO_SEL - 1: format decoded from the opcode (imm_sel ignored),
//              0: format taken from imm_sel.
// Ports:
//   clk  - clock, all state on the rising edge.
//   rst  - synchronous active-high reset (wins over flush).
//   bus  - imm_gen_pipe_if.slave: input/output handshakes, flush, data.
// Build option:
//   IMM_ILLEGAL_CHECK_EN - adds bus.out_illegal, set for an unmapped opcode
//                          (AUTO_SEL=1) or imm_sel=111 (AUTO_SEL=0).
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 5,
   parameter int AUTO_SEL = 0
) (
   input logic           clk,
   input logic           rst,
   imm_gen_pipe_if.slave bus
);

   localparam logic [2:0] FMT_I     = 3'b000;
   localparam logic [2:0] FMT_S     = 3'b001;
   localparam logic [2:0] FMT_B     = 3'b010;
   localparam logic [2:0] FMT_J     = 3'b011;
   localparam logic [2:0] FMT_U     = 3'b100;
   localparam logic [2:0] FMT_SHAMT = 3'b101;
   localparam logic [2:0] FMT_ZIMM  = 3'b110;
   localparam logic [2:0] FMT_ZERO  = 3'b111;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_CHECK_EN
      logic             ill;
`endif
   } entry_t;

   // EMPTY: main invalid; ONE: main valid; FULL: main and skid valid.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            rdy_q;
   entry_t          main_q, skid_q, new_entry;
   logic            accept, pop;
   logic            ld_main, ld_skid, mv_skid;
   logic [2:0]      auto_fmt, fmt;
   logic [31:0]     v32;
   logic [XLEN-1:0] imm_ext;

   // ---------------------------------------------------------------------
   // Format selection
   // ---------------------------------------------------------------------
   always_comb begin
      auto_fmt = FMT_ZERO;
      case (bus.instr[6:0])
         // funct3 001 (slli) and 101 (srli/srai) are exactly funct3[1:0]=01
         OP_IMM:            auto_fmt = (bus.instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
         OP_LOAD, OP_JALR:  auto_fmt = FMT_I;
         OP_STORE:          auto_fmt = FMT_S;
         OP_BRANCH:         auto_fmt = FMT_B;
         OP_JAL:            auto_fmt = FMT_J;
         OP_LUI, OP_AUIPC:  auto_fmt = FMT_U;
         // CSR immediate forms (csrr*i) have funct3[2] set
         OP_SYSTEM:         auto_fmt = bus.instr[14] ? FMT_ZIMM : FMT_I;
         default:           auto_fmt = FMT_ZERO;
      endcase
      fmt = (AUTO_SEL != 0) ? auto_fmt : bus.imm_sel;
   end

   // ---------------------------------------------------------------------
   // Immediate assembly. Every format is first built as a 32-bit value that
   // is already correctly extended to 32 bits; zero-extended formats have
   // bit 31 clear, so a plain sign extension of bit 31 to XLEN is right for
   // all of them.
   // ---------------------------------------------------------------------
   always_comb begin
      v32 = '0;
      case (fmt)
         FMT_I:     v32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
         FMT_S:     v32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
         FMT_B:     v32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                           bus.instr[30:25], bus.instr[11:8], 1'b0};
         FMT_J:     v32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                           bus.instr[20], bus.instr[30:21], 1'b0};
         FMT_U:     v32 = {bus.instr[31:12], 12'h000};
         FMT_SHAMT: v32 = (XLEN == 64) ? {26'd0, bus.instr[25:20]}
                                       : {27'd0, bus.instr[24:20]};
         FMT_ZIMM:  v32 = {27'd0, bus.instr[19:15]};
         default:   v32 = '0;
      endcase
      imm_ext        = {XLEN{v32[31]}};
      imm_ext[31:0]  = v32;
   end

   always_comb begin
      new_entry     = '0;
      new_entry.imm = imm_ext;
      new_entry.tag = bus.in_tag;
`ifdef IMM_ILLEGAL_CHECK_EN
      // A mapped opcode never decodes to FMT_ZERO, so it marks "unmapped".
      new_entry.ill = (AUTO_SEL != 0) ? (auto_fmt == FMT_ZERO)
                                      : (bus.imm_sel == FMT_ZERO);
`endif
   end

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   assign accept = bus.in_valid & rdy_q;
   assign pop    = (state != S_EMPTY) & bus.out_ready;

   // ---------------------------------------------------------------------
   // Control FSM: state register / next state / output decode
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         // Registered ready: open whenever the skid slot will be free.
         rdy_q <= (state_nxt != S_FULL);
      end
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: if (accept)       state_nxt = S_ONE;
            S_ONE:   if (accept & !pop) state_nxt = S_FULL;
                     else if (!accept & pop) state_nxt = S_EMPTY;
            S_FULL:  if (pop)          state_nxt = S_ONE;
            default:                   state_nxt = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      ld_main = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
      if (!bus.flush) begin
         case (state)
            S_EMPTY: ld_main = accept;
            S_ONE: begin
               ld_main = accept & pop;
               ld_skid = accept & !pop;
            end
            S_FULL:  mv_skid = pop;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Data registers: only written on a load or move so idle cycles do not
   // toggle the wide immediate fields.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main)      main_q <= new_entry;
         else if (mv_skid) main_q <= skid_q;
         if (ld_skid)      skid_q <= new_entry;
      end
   end

   assign bus.in_ready    = rdy_q;
   assign bus.out_valid   = (state != S_EMPTY);
   assign bus.out_imm     = main_q.imm;
   assign bus.out_tag     = main_q.tag;
`ifdef IMM_ILLEGAL_CHECK_EN
   assign bus.out_illegal = main_q.ill;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives two generators with the same stimulus:
//   dut_a - XLEN=32, AUTO_SEL=1 (format from opcode)
//   dut_m - XLEN=64, AUTO_SEL=0 (format from imm_sel)
// Expected entries are queued at accept time and compared when popped.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instr     = '0;
   logic [2:0]  imm_sel   = '0;
   logic [4:0]  in_tag    = '0;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus_a ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus_m ();

   assign bus_a.flush = flush;     assign bus_m.flush = flush;
   assign bus_a.in_valid = in_valid; assign bus_m.in_valid = in_valid;
   assign bus_a.instr = instr;     assign bus_m.instr = instr;
   assign bus_a.imm_sel = imm_sel; assign bus_m.imm_sel = imm_sel;
   assign bus_a.in_tag = in_tag;   assign bus_m.in_tag = in_tag;
   assign bus_a.out_ready = out_ready; assign bus_m.out_ready = out_ready;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .AUTO_SEL(1)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave));
   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .AUTO_SEL(0)) dut_m (
      .clk(clk), .rst(rst), .bus(bus_m.slave));

   typedef struct {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        ill;
   } exp_t;

   exp_t qa[$], qm[$];
   exp_t cur_a, cur_m;
   int   n_chk = 0, n_pass = 0;
   bit   done = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
   endtask

   // reference model
   function automatic logic [2:0] ref_fmt(input logic [31:0] i);
      case (i[6:0])
         7'h13:        return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd5 : 3'd0;
         7'h03, 7'h67: return 3'd0;
         7'h23:        return 3'd1;
         7'h63:        return 3'd2;
         7'h6F:        return 3'd3;
         7'h37, 7'h17: return 3'd4;
         7'h73:        return i[14] ? 3'd6 : 3'd0;
         default:      return 3'd7;
      endcase
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] f, input int xl);
      logic [63:0] r;
      case (f)
         3'd0: r = {{52{i[31]}}, i[31:20]};
         3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
         3'd2: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd4: r = {{32{i[31]}}, i[31:12], 12'h000};
         3'd5: r = (xl == 64) ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
         3'd6: r = {59'd0, i[19:15]};
         default: r = '0;
      endcase
      if (xl == 32) r[63:32] = '0;
      return r;
   endfunction

   // Offer one entry; hold it until accepted (bounded wait).
   task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [4:0] t,
                       input logic [63:0] ea, input logic [63:0] em);
      bit ok;
      instr = i; imm_sel = s; in_tag = t;
      cur_a.imm = ea; cur_a.tag = t; cur_a.ill = (ref_fmt(i) == 3'd7);
      cur_m.imm = em; cur_m.tag = t; cur_m.ill = (s == 3'd7);
      in_valid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         ok = bus_a.in_ready;
         @(posedge clk); #1;
         if (ok) break;
         if (n >= 200) begin chk("send_accept", ok, 1); break; end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input logic [4:0] t);
      logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                                7'h37, 7'h17, 7'h73, 7'h7F, 7'h33};
      logic [31:0] r, i;
      logic [2:0]  s;
      r = $urandom();
      i = {r[31:7], ops[$urandom_range(0, 10)]};
      s = 3'($urandom_range(0, 7));
      send(i, s, t, ref_imm(i, ref_fmt(i), 32), ref_imm(i, s, 64));
   endtask

   // scoreboard monitors, sampled on the falling edge
   logic [63:0] hold_a_imm, hold_m_imm;
   logic [4:0]  hold_a_tag, hold_m_tag;
   bit          hold_a = 1'b0, hold_m = 1'b0;

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst || flush) begin
         qa.delete(); hold_a = 1'b0;
      end else begin
         if (hold_a) begin
            chk("stable_imm_a", 64'(bus_a.out_imm), hold_a_imm);
            chk("stable_tag_a", 64'(bus_a.out_tag), 64'(hold_a_tag));
         end
         if (bus_a.out_valid && out_ready) begin
            chk("q_nonempty_a", 64'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
               e = qa.pop_front();
               chk("imm_a", 64'(bus_a.out_imm), e.imm);
               chk("tag_a", 64'(bus_a.out_tag), 64'(e.tag));
`ifdef IMM_ILLEGAL_CHECK_EN
               chk("ill_a", 64'(bus_a.out_illegal), 64'(e.ill));
`endif
            end
         end
         hold_a = bus_a.out_valid && !out_ready;
         hold_a_imm = 64'(bus_a.out_imm);
         hold_a_tag = bus_a.out_tag;
         if (in_valid && bus_a.in_ready) qa.push_back(cur_a);
      end
   end

   always @(negedge clk) begin : mon_m
      exp_t e;
      if (rst || flush) begin
         qm.delete(); hold_m = 1'b0;
      end else begin
         if (hold_m) begin
            chk("stable_imm_m", bus_m.out_imm, hold_m_imm);
            chk("stable_tag_m", 64'(bus_m.out_tag), 64'(hold_m_tag));
         end
         if (bus_m.out_valid && out_ready) begin
            chk("q_nonempty_m", 64'(qm.size() != 0), 1);
            if (qm.size() != 0) begin
               e = qm.pop_front();
               chk("imm_m", bus_m.out_imm, e.imm);
               chk("tag_m", 64'(bus_m.out_tag), 64'(e.tag));
`ifdef IMM_ILLEGAL_CHECK_EN
               chk("ill_m", 64'(bus_m.out_illegal), 64'(e.ill));
`endif
            end
         end
         hold_m = bus_m.out_valid && !out_ready;
         hold_m_imm = bus_m.out_imm;
         hold_m_tag = bus_m.out_tag;
         if (in_valid && bus_m.in_ready) qm.push_back(cur_m);
      end
   end

   task automatic chk_idle(input string name);
      chk({name, "_vld_a"}, 64'(bus_a.out_valid), 0);
      chk({name, "_vld_m"}, 64'(bus_m.out_valid), 0);
      chk({name, "_rdy_a"}, 64'(bus_a.in_ready), 1);
      chk({name, "_rdy_m"}, 64'(bus_m.in_ready), 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_idle("rst");
      chk("rst_imm_a", 64'(bus_a.out_imm), 0);
      chk("rst_imm_m", bus_m.out_imm, 0);
      chk("rst_tag_a", 64'(bus_a.out_tag), 0);
      rst = 1'b0;
      out_ready = 1'b1;

      // directed formats
      send(32'hFFF00093, 3'd0, 5'd1, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      send(32'hFE512E23, 3'd1, 5'd2, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      send(32'hFE000CE3, 3'd2, 5'd3, 64'h0000_0000_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
      send(32'hFFDFF0EF, 3'd3, 5'd4, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      send(32'h123450B7, 3'd4, 5'd5, 64'h0000_0000_1234_5000, 64'h0000_0000_1234_5000);
      send(32'h01F0D093, 3'd5, 5'd6, 64'h1F, 64'h1F);
      send(32'h300FD0F3, 3'd6, 5'd7, 64'h1F, 64'h1F);
      send(32'h300F9073, 3'd6, 5'd8, 64'h300, 64'h1F);
      send(32'h43F0D093, 3'd5, 5'd9, 64'h1F, 64'h3F);
      send(32'h0000007F, 3'd7, 5'd10, 64'h0, 64'h0);
      repeat (3) @(posedge clk);
      #1;

      // back-pressure: third entry held off, then drained with no bubble
      out_ready = 1'b0;
      send(32'hFFF00093, 3'd0, 5'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rdy_one_a", 64'(bus_a.in_ready), 1);
      send(32'h123450B7, 3'd4, 5'd2, 64'h1234_5000, 64'h1234_5000);
      chk("rdy_full_a", 64'(bus_a.in_ready), 0);
      chk("rdy_full_m", 64'(bus_m.in_ready), 0);
      fork
         send(32'hFE512E23, 3'd1, 5'd3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("held_q_a", 64'(qa.size()), 2);
            chk("held_rdy_a", 64'(bus_a.in_ready), 0);
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("nobubble_a", 64'(bus_a.out_valid), 1);
               chk("nobubble_m", 64'(bus_m.out_valid), 1);
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      chk("bp_drained_a", 64'(qa.size()), 0);

      // flush in FULL with a new entry offered
      out_ready = 1'b0;
      send(32'hFFF00093, 3'd0, 5'd11, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      send(32'hFE000CE3, 3'd2, 5'd12, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
      instr = 32'h123450B7; imm_sel = 3'd4; in_tag = 5'd13; in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk_idle("flush");
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("flush_quiet_a", 64'(bus_a.out_valid), 0);
      end

      // reset while FULL
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'hFE512E23, 3'd1, 5'd14, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      send(32'h0000007F, 3'd7, 5'd15, 64'h0, 64'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_idle("midrst");
      chk("midrst_imm_a", 64'(bus_a.out_imm), 0);
      chk("midrst_imm_m", bus_m.out_imm, 0);
      chk("midrst_tag_m", 64'(bus_m.out_tag), 0);
`ifdef IMM_ILLEGAL_CHECK_EN
      chk("midrst_ill_a", 64'(bus_a.out_illegal), 0);
`endif
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_quiet_m", 64'(bus_m.out_valid), 0);
      end
      @(posedge clk); #1;

      // random traffic with random back-pressure
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               send_rand(5'(k));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int k = 0; k < 20 && (qa.size() != 0 || qm.size() != 0); k++) @(posedge clk);
      #1;
      chk("drain_a", 64'(qa.size()), 0);
      chk("drain_m", 64'(qm.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
